// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Boot-time writer for the instruction memory. Receives a program
//            as a byte stream (valid/ready), packs each four bytes MSB-first
//            into a 32-bit word and writes it to consecutive word-aligned
//            addresses. The processor is held in reset until the load ends
//            successfully.
// Ports    : clk, reset (sync, active-high)
//            start_i, length_i         - load request and length in words
//            byte_valid_i/byte_data_i  - byte source, byte_ready_o back
//            mem_write_o/address/data  - instruction memory write port
//            cpu_reset_o, busy_o, done_o, error_o, word_count_o - status
// Options  : LOADER_CHECKSUM_EN - when defined, one trailer byte follows the
//            program and must equal the XOR of all program bytes.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int MEMORY_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] length_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_write_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] word_count_o
);

    // 17 bits so a depth of 65536 still compares correctly against length_i
    localparam logic [16:0] c_max_len = 17'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
`ifdef LOADER_CHECKSUM_EN
        ,S_CHECK = 3'd5
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] length_q, length_d;
    logic [15:0] word_count_q, word_count_d;
    logic [1:0]  byte_index_q, byte_index_d;
    logic [23:0] word_q, word_d;       // the three bytes preceding the 4th
    logic [31:0] addr_q, addr_d;       // held after the strobe until next write
    logic [31:0] data_q, data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic w_len_ok;
    logic w_accept;

    // Moore output decode
    assign byte_ready_o  = (state_q == S_RECV)
`ifdef LOADER_CHECKSUM_EN
                         || (state_q == S_CHECK)
`endif
                         ;
    assign mem_write_o   = (state_q == S_WRITE);
    assign mem_address_o = addr_q;
    assign mem_data_o    = data_q;
    assign cpu_reset_o   = (state_q != S_DONE);
    assign busy_o        = (state_q == S_RECV) || (state_q == S_WRITE)
`ifdef LOADER_CHECKSUM_EN
                         || (state_q == S_CHECK)
`endif
                         ;
    assign done_o        = (state_q == S_DONE);
    assign error_o       = (state_q == S_ERROR);
    assign word_count_o  = word_count_q;

    assign w_len_ok = (length_i != 16'd0) && ({1'b0, length_i} <= c_max_len);
    assign w_accept = byte_valid_i && byte_ready_o;

    always_comb begin
        state_d      = state_q;
        length_d     = length_q;
        word_count_d = word_count_q;
        byte_index_d = byte_index_q;
        word_d       = word_q;
        addr_d       = addr_q;
        data_d       = data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    if (w_len_ok) begin
                        state_d      = S_RECV;
                        length_d     = length_i;
                        word_count_d = 16'd0;
                        byte_index_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d       = 8'd0;
`endif
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_RECV: begin
                if (w_accept) begin
                    word_d       = {word_q[15:0], byte_data_i};
                    byte_index_d = byte_index_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d       = csum_q ^ byte_data_i;
`endif
                    if (byte_index_q == 2'd3) begin
                        // Capture the write so it stays stable past the strobe
                        state_d = S_WRITE;
                        addr_d  = {14'd0, word_count_q, 2'b00};
                        data_d  = {word_q, byte_data_i};
                    end
                end
            end
            S_WRITE: begin
                word_count_d = word_count_q + 16'd1;
                if (word_count_d == length_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_accept) begin
                    state_d = (byte_data_i == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            length_q     <= 16'd0;
            word_count_q <= 16'd0;
            byte_index_q <= 2'd0;
            word_q       <= 24'd0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            length_q     <= length_d;
            word_count_q <= word_count_d;
            byte_index_q <= byte_index_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Self-checking bench for program_loader. Loads byte streams with
//            various lengths and valid-bubble patterns, and compares the
//            memory writes and status against words built directly from the
//            transmitted bytes. Honours LOADER_CHECKSUM_EN (trailer byte).
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [15:0] length_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic        cpu_reset_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [15:0] word_count_o;

    program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .length_i     (length_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_write_o  (mem_write_o),
        .mem_address_o(mem_address_o),
        .mem_data_o   (mem_data_o),
        .cpu_reset_o  (cpu_reset_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .word_count_o (word_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        wr_q[$];   // every write strobe observed
    wr_t        mon_w;
    logic [7:0] tx_q[$];   // bytes to offer, in order

    always @(negedge clk) begin
        if (mem_write_o === 1'b1) begin
            mon_w.a = mem_address_o;
            mon_w.d = mem_data_o;
            wr_q.push_back(mon_w);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Called at a negedge; returns at a negedge with start_i low.
    task automatic pulse_start(input logic [15:0] len);
        start_i  = 1'b1;
        length_i = len;
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    // Offer tx_q in order. mode 0: always valid, 1: valid every other
    // cycle, 2: random bubbles. Called and returns at a negedge.
    task automatic send_bytes(input int mode);
        int  idx   = 0;
        int  guard = 0;
        int  limit = 8 * tx_q.size() + 50;
        bit  v;
        bit  rdy;
        while (idx < tx_q.size()) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid_i = v;
            byte_data_i  = v ? tx_q[idx] : 8'($urandom);
            rdy          = byte_ready_o;
            @(posedge clk);
            if (v && rdy) idx++;
            @(negedge clk);
            guard++;
            if (guard > limit) begin
                timeout("send_bytes");
                break;
            end
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done_o || error_o)) begin
            @(negedge clk);
            k++;
            if (k > 20) begin
                timeout("wait_end");
                break;
            end
        end
    endtask

    // Build the expected words straight from the byte stream and compare.
    task automatic check_writes(input int len);
        logic [31:0] w;
        check("write_count", 32'(wr_q.size()), 32'(len));
        for (int i = 0; i < len; i++) begin
            w = {tx_q[4*i], tx_q[4*i+1], tx_q[4*i+2], tx_q[4*i+3]};
            if (i < wr_q.size()) begin
                check($sformatf("addr[%0d]", i), wr_q[i].a, 32'(4 * i));
                check($sformatf("data[%0d]", i), wr_q[i].d, w);
            end
        end
    endtask

    function automatic logic [7:0] xor_of(input int n);
        logic [7:0] x = 8'd0;
        for (int i = 0; i < n; i++) x ^= tx_q[i];
        return x;
    endfunction

    task automatic run_load(input logic [15:0] len, input int mode, input bit exp_err);
        wr_q.delete();
        tx_q.delete();
        pulse_start(len);
        if (exp_err) begin
            check("err_error", 32'(error_o), 32'd1);
            check("err_cpu_reset", 32'(cpu_reset_o), 32'd1);
            check("err_busy", 32'(busy_o), 32'd0);
            check("err_done", 32'(done_o), 32'd0);
            repeat (3) @(negedge clk);
            check("err_no_writes", 32'(wr_q.size()), 32'd0);
        end else begin
            check("start_ready", 32'(byte_ready_o), 32'd1);
            for (int i = 0; i < 4 * int'(len); i++) tx_q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
            tx_q.push_back(xor_of(4 * int'(len)));
`endif
            send_bytes(mode);
            wait_end();
            check("load_done", 32'(done_o), 32'd1);
            check("load_error", 32'(error_o), 32'd0);
            check("load_cpu_reset", 32'(cpu_reset_o), 32'd0);
            check("load_busy", 32'(busy_o), 32'd0);
            check("load_word_count", 32'(word_count_o), 32'(len));
            check_writes(int'(len));
        end
    endtask

    typedef struct {
        logic [15:0] len;
        int          mode;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset        = 1'b1;
        start_i      = 1'b0;
        length_i     = 16'd0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'd0;

        vecs.push_back('{16'd3,   1, 1'b0});
        vecs.push_back('{16'd0,   0, 1'b1});
        vecs.push_back('{16'd257, 0, 1'b1});
        vecs.push_back('{16'd1,   0, 1'b0});
        vecs.push_back('{16'd5,   2, 1'b0});
        vecs.push_back('{16'hFFFF,0, 1'b1});
        vecs.push_back('{16'd256, 0, 1'b0});
        vecs.push_back('{16'd2,   1, 1'b0});

        // ---- reset state
        repeat (2) @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready_o), 32'd0);
        check("rst_mem_write", 32'(mem_write_o), 32'd0);
        check("rst_mem_address", mem_address_o, 32'd0);
        check("rst_mem_data", mem_data_o, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_word_count", 32'(word_count_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---- single word, cycle-exact
        wr_q.delete();
        tx_q = '{8'h20, 8'h08, 8'h00, 8'h05};
        pulse_start(16'd1);
        check("sw_ready_latency", 32'(byte_ready_o), 32'd1);
        check("sw_busy", 32'(busy_o), 32'd1);
        send_bytes(0);
        check("sw_strobe", 32'(mem_write_o), 32'd1);
        check("sw_addr", mem_address_o, 32'h0);
        check("sw_data", mem_data_o, 32'h20080005);
        check("sw_ready_in_write", 32'(byte_ready_o), 32'd0);
        check("sw_cpu_reset_in_write", 32'(cpu_reset_o), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        tx_q = '{8'h2D};
        send_bytes(0);
`else
        @(negedge clk);
`endif
        check("sw_done", 32'(done_o), 32'd1);
        check("sw_cpu_reset", 32'(cpu_reset_o), 32'd0);
        check("sw_strobe_off", 32'(mem_write_o), 32'd0);
        check("sw_data_held", mem_data_o, 32'h20080005);
        check("sw_word_count", 32'(word_count_o), 32'd1);
        check("sw_write_count", 32'(wr_q.size()), 32'd1);

        // ---- reset in the middle of the second word
        wr_q.delete();
        tx_q.delete();
        for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom));
        pulse_start(16'd2);
        send_bytes(0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("mid_busy", 32'(busy_o), 32'd0);
        check("mid_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("mid_word_count", 32'(word_count_o), 32'd0);
        check("mid_ready", 32'(byte_ready_o), 32'd0);
        check("mid_done", 32'(done_o), 32'd0);
        repeat (5) @(negedge clk);
        check_writes(1);

        // ---- table of loads (exercises DONE/ERROR -> RECV/ERROR transitions)
        foreach (vecs[i]) run_load(vecs[i].len, vecs[i].mode, vecs[i].exp_err);

        // ---- randomized loads
        for (int r = 0; r < 6; r++) run_load(16'($urandom_range(1, 8)), 2, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // ---- trailer mismatch, then matching trailer
        wr_q.delete();
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        pulse_start(16'd1);
        send_bytes(0);
        wait_end();
        check("cs_bad_error", 32'(error_o), 32'd1);
        check("cs_bad_cpu_reset", 32'(cpu_reset_o), 32'd1);
        check("cs_bad_word_count", 32'(word_count_o), 32'd1);
        wr_q.delete();
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        pulse_start(16'd1);
        send_bytes(0);
        wait_end();
        check("cs_good_done", 32'(done_o), 32'd1);
        check("cs_good_cpu_reset", 32'(cpu_reset_o), 32'd0);
        check_writes(1);
`endif

        // start_i must be ignored while a load is active
        wr_q.delete();
        tx_q.delete();
        pulse_start(16'd1);
        pulse_start(16'd0);
        check("ignore_start_busy", 32'(busy_o), 32'd1);
        check("ignore_start_error", 32'(error_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time writer for the processor's instruction memory. It receives a program as a byte stream over a valid/ready handshake and packs each group of four bytes into a big-endian 32-bit word. Each word is written into the program memory's write port at consecutive word-aligned addresses. The processor is held in reset until the whole program has been loaded. The block sits beside the processor top level, between the host/UART byte source and the instruction memory that the fetch stage reads.

## Interface
- MEMORY_DEPTH, 256, instruction memory depth in 32-bit words; upper bound on load length
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start_i  input  1  single-cycle request to begin a load; sampled in IDLE, DONE, ERROR only
- length_i  input  16  number of words to load; sampled in the start_i cycle
- byte_valid_i  input  1  byte_data_i holds a valid byte
- byte_data_i  input  8  program byte, most significant byte of each word first
- byte_ready_o  output  1  loader accepts a byte this cycle
- mem_write_o  output  1  one-cycle write strobe to instruction memory
- mem_address_o  output  32  byte address of the write, always a multiple of 4
- mem_data_o  output  32  instruction word to write
- cpu_reset_o  output  1  holds the processor in reset while high
- busy_o  output  1  a load is in progress
- done_o  output  1  last load completed successfully
- error_o  output  1  last load rejected or failed
- word_count_o  output  16  words written in the current or last load

## Operation
- Moore FSM with states IDLE, RECV, WRITE, CHECK, DONE, ERROR. All outputs are decoded from registered state and datapath registers.
- IDLE → RECV when start_i=1 and 1 ≤ length_i ≤ MEMORY_DEPTH. In the same transition the length is latched, word_count and byte_index are cleared, and the checksum accumulator is cleared.
- IDLE/DONE/ERROR → ERROR when start_i=1 and length_i is 0 or greater than MEMORY_DEPTH.
- DONE/ERROR → RECV when start_i=1 and length_i is valid. A reload is allowed at any time outside an active load.
- RECV:
  - byte_ready_o=1.
  - On byte_valid_i && byte_ready_o, shift the byte in: word = {word[23:0], byte_data_i}, and increment byte_index modulo 4.
  - Accepting the 4th byte moves to WRITE.
- WRITE, lasting exactly one cycle:
  - byte_ready_o=0 and mem_write_o=1.
  - mem_address_o = word_count×4, computed as a zero-extended 32-bit value.
  - mem_data_o = the assembled word.
  - Next cycle word_count increments. If the new count equals the latched length, go to DONE (or CHECK when the checksum is enabled); otherwise go back to RECV.
- CHECK: present only with LOADER_CHECKSUM_EN; see Configuration.
- DONE: done_o=1 and cpu_reset_o=0.
- ERROR: error_o=1 and cpu_reset_o=1.
- cpu_reset_o is 1 in IDLE, RECV, WRITE, CHECK and ERROR. The processor therefore never runs a partially loaded program.
- busy_o is 1 in RECV, WRITE and CHECK.
- start_i is ignored during RECV, WRITE and CHECK.
- A byte offered while byte_ready_o=0 is not consumed; the source must hold it.
- reset in any state:
  - Return to IDLE.
  - Discard any partial word; no write is issued.
  - Clear the checksum.
- Reset values: byte_ready_o=0, mem_write_o=0, mem_address_o=0, mem_data_o=0, cpu_reset_o=1, busy_o=0, done_o=0, error_o=0, word_count_o=0.

## Timing
- Latency from start_i to byte_ready_o: 1 cycle.
- Throughput: at least 5 cycles per word (4 accept cycles plus 1 WRITE cycle).
- mem_write_o is asserted in the cycle after the 4th byte is accepted.
- mem_address_o and mem_data_o are stable for the whole strobe cycle and hold their values afterwards.
- done_o rises, and cpu_reset_o falls, in the cycle after the final WRITE (or after the CHECK accept when the checksum is enabled).
- error_o rises in the cycle after an invalid start_i.
- Bubbles on byte_valid_i stall RECV indefinitely; there is no timeout.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Every accepted byte is XORed into an 8-bit accumulator.
  - After the last WRITE the FSM enters CHECK with byte_ready_o=1 and accepts exactly one trailer byte.
  - If the trailer equals the accumulator, go to DONE; otherwise go to ERROR.
  - word_count_o still reports the number of words written.
- LOADER_CHECKSUM_EN undefined:
  - No accumulator or CHECK state.
  - The last WRITE goes directly to DONE.
  - No trailer byte is consumed.

## Test plan
- **Reset:** reset high for 2 cycles → all outputs at their reset values, cpu_reset_o=1, byte_ready_o=0.
- **Single word:** start_i with length_i=1, then bytes 0x20,0x08,0x00,0x05 → one mem_write_o pulse with address 0x0, data 0x20080005; then done_o=1 and cpu_reset_o=0.
- **Three words with stalls:** length_i=3, byte_valid_i toggled every other cycle → writes at 0x0, 0x4 and 0x8 with the correct data; word_count_o=3; no write while valid is low.
- **Invalid length:** start_i with length_i=0, then again with length_i=257 → error_o=1 and no writes in both cases; a following start_i with length_i=1 recovers to a normal load.
- **Reset mid-load:** length_i=2, reset asserted after 6 bytes → only the write at 0x0 occurs; state returns to IDLE; word_count_o=0; cpu_reset_o=1.
- **Checksum (LOADER_CHECKSUM_EN defined):** word 0x01020304 with trailer 0x04 → done_o=1. The same word with trailer 0x05 → error_o=1 and cpu_reset_o stays 1.
